// File: rtl/divisor_punto_fijo.sv
// -----------------------------------------------------------------------------
// divisor_punto_fijo
// Sequential signed fixed-point divider, Q(Magnitud).(Presicion) format.
// Computes Y = A / B with a restoring shift-subtract loop, one quotient bit per
// clock, then saturates to the representable range.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     operation request, sampled only while idle
//   A, B      signed dividend / divisor (two's complement, Width bits)
//   Y         signed quotient, held until the next done
//   busy      high while an operation is in progress
//   done      one-cycle pulse when Y and the flags are valid
//   ovf       result saturated (divide-by-zero included), held
//   div_zero  divisor was zero, held
// -----------------------------------------------------------------------------
module divisor_punto_fijo #(
    parameter int unsigned Width     = 16,
    parameter int unsigned Signo     = 1,
    parameter int unsigned Magnitud  = 3,
    parameter int unsigned Presicion = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic [Width-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             div_zero
);

    localparam int unsigned Nbits = Width + Presicion;
    localparam int unsigned CntW  = $clog2(Nbits);

    localparam logic [CntW-1:0]  CntLast = CntW'(Nbits - 1);
    localparam logic [Width-1:0] YMax    = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] YMin    = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Nbits-1:0] QMaxPos = {{(Presicion+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic [Nbits-1:0] QMaxNeg = QMaxPos + 1'b1;

    if (Width != Signo + Magnitud + Presicion) begin : g_fmt_check
        $error("Width must equal Signo + Magnitud + Presicion");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e           r_state, w_state_d;
    logic             r_sign, w_sign_d;
    logic             r_b_zero, w_b_zero_d;
    logic [Width-1:0] r_abs_b, w_abs_b_d;
    logic [Nbits-1:0] r_dividend, w_dividend_d;
    // Remainder is always < |B| <= 2^(Width-1) after each step, so Width bits
    // suffice in storage; the shifted trial value needs Width+1.
    logic [Width-1:0] r_rem, w_rem_d;
    logic [Nbits-1:0] r_quot, w_quot_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;
    logic [Width-1:0] r_y, w_y_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic             r_ovf, w_ovf_d;
    logic             r_div_zero, w_div_zero_d;

    logic [Width-1:0] w_abs_a, w_abs_b;
    logic [Width:0]   w_rem_shift;
    logic             w_rem_ge;
    logic [Width-1:0] w_rem_sub;
    logic [Width-1:0] w_q_neg;

    // |0x8000| stays 0x8000, which is the intended unsigned magnitude.
    assign w_abs_a     = A[Width-1] ? (~A + 1'b1) : A;
    assign w_abs_b     = B[Width-1] ? (~B + 1'b1) : B;
    assign w_rem_shift = {r_rem, r_dividend[Nbits-1]};
    assign w_rem_ge    = w_rem_shift >= {1'b0, r_abs_b};
    assign w_rem_sub   = w_rem_shift[Width-1:0] - r_abs_b;
    assign w_q_neg     = ~r_quot[Width-1:0] + 1'b1;

    always_comb begin
        w_state_d    = r_state;
        w_sign_d     = r_sign;
        w_b_zero_d   = r_b_zero;
        w_abs_b_d    = r_abs_b;
        w_dividend_d = r_dividend;
        w_rem_d      = r_rem;
        w_quot_d     = r_quot;
        w_cnt_d      = r_cnt;
        w_y_d        = r_y;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_ovf_d      = r_ovf;
        w_div_zero_d = r_div_zero;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_sign_d     = A[Width-1] ^ B[Width-1];
                    w_b_zero_d   = (B == '0);
                    w_abs_b_d    = w_abs_b;
                    w_dividend_d = {w_abs_a, {Presicion{1'b0}}};
                    w_rem_d      = '0;
                    w_quot_d     = '0;
                    w_cnt_d      = '0;
                    w_busy_d     = 1'b1;
                    w_state_d    = StCalc;
                end
            end
            StCalc: begin
                w_dividend_d = {r_dividend[Nbits-2:0], 1'b0};
                w_rem_d      = w_rem_ge ? w_rem_sub : w_rem_shift[Width-1:0];
                w_quot_d     = {r_quot[Nbits-2:0], w_rem_ge};
                w_cnt_d      = r_cnt + 1'b1;
                if (r_cnt == CntLast) begin
                    w_state_d = StFin;
                end
            end
            StFin: begin
                w_div_zero_d = r_b_zero;
                if (r_b_zero) begin
                    // B was zero: sign equals the sign of A here.
                    w_y_d   = r_sign ? YMin : YMax;
                    w_ovf_d = 1'b1;
                end else if (!r_sign && (r_quot > QMaxPos)) begin
                    w_y_d   = YMax;
                    w_ovf_d = 1'b1;
                end else if (r_sign && (r_quot > QMaxNeg)) begin
                    w_y_d   = YMin;
                    w_ovf_d = 1'b1;
                end else begin
                    w_y_d   = r_sign ? w_q_neg : r_quot[Width-1:0];
                    w_ovf_d = 1'b0;
                end
                w_done_d  = 1'b1;
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_sign     <= 1'b0;
            r_b_zero   <= 1'b0;
            r_abs_b    <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_y        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_sign     <= w_sign_d;
            r_b_zero   <= w_b_zero_d;
            r_abs_b    <= w_abs_b_d;
            r_dividend <= w_dividend_d;
            r_rem      <= w_rem_d;
            r_quot     <= w_quot_d;
            r_cnt      <= w_cnt_d;
            r_y        <= w_y_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_ovf      <= w_ovf_d;
            r_div_zero <= w_div_zero_d;
        end
    end

    assign Y        = r_y;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ovf      = r_ovf;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// -----------------------------------------------------------------------------
// tb_divisor_punto_fijo
// Scoreboard bench for divisor_punto_fijo: the driver pushes the expected
// result of every accepted operation; a monitor pops and compares on done.
// -----------------------------------------------------------------------------
module tb_divisor_punto_fijo;

    localparam int Lat = 29;

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        logic        dz;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] Y;
    logic        busy, done, ovf, div_zero;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    divisor_punto_fijo dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: exact rational quotient truncated toward zero, then clamped.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb, ma, mb, q;
        bit     neg;
        sa = $signed(a);
        sb = $signed(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        e.k = 0;
        e.dz = (sb == 0);
        if (sb == 0) begin
            e.y = (sa >= 0) ? 16'h7FFF : 16'h8000;
            e.ovf = 1'b1;
        end else begin
            q = (ma * 4096) / mb;
            if (!neg && q > 32767) begin
                e.y = 16'h7FFF; e.ovf = 1'b1;
            end else if (neg && q > 32768) begin
                e.y = 16'h8000; e.ovf = 1'b1;
            end else begin
                e.y = neg ? 16'(-q) : 16'(q);
                e.ovf = 1'b0;
            end
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("Y", Y, e.y);
                check("ovf", ovf, e.ovf);
                check("div_zero", div_zero, e.dz);
                check("latency", cyc, e.k + Lat);
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b);
        e.k = cyc;
        exp_q.push_back(e);
        check("busy_after_start", busy, 1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("timeout_waiting_done", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_Y"}, Y, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_div_zero"}, div_zero, 0);
    endtask

    initial begin
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(16'h1000, 16'h2000); wait_idle();
        issue(16'hF000, 16'h0C00); wait_idle();
        issue(16'h7000, 16'h0800); wait_idle();
        issue(16'hC000, 16'h0800); wait_idle();
        issue(16'h1234, 16'h0000); wait_idle();
        issue(16'h8000, 16'h0000); wait_idle();
        issue(16'h0000, 16'h0300); wait_idle();
        issue(16'h8000, 16'hF000); wait_idle();
        issue(16'h8000, 16'h1000); wait_idle();

        // Start while busy is ignored
        @(negedge clk);
        issue(16'h3000, 16'h1800);
        repeat (9) @(posedge clk);
        A = 16'h0100;
        B = 16'h7000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_held_on_ignored_start", busy, 1);
        wait_idle();

        // Start during the done cycle is accepted
        @(negedge clk);
        issue(16'h2000, 16'h0600);
        begin
            int i;
            for (i = 0; i < 40 && !done; i++) @(negedge clk);
            check("done_seen", done, 1);
        end
        issue(16'hE000, 16'h0500);
        wait_idle();

        // Asynchronous reset mid-operation
        @(negedge clk);
        issue(16'h1800, 16'h0400);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (35) @(negedge clk);
        issue(16'h0C00, 16'h0400);
        wait_idle();

        // Randomized operands
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a, b;
            @(negedge clk);
            a = 16'($urandom);
            case ($urandom % 8)
                0: b = 16'h0000;
                1: b = 16'($urandom % 16);
                2: b = -16'($urandom % 16);
                default: b = 16'($urandom);
            endcase
            issue(a, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
